// File: rtl/sfp_accum.sv
// sfp_accum
// Special-function stage that sits behind the psum SRAM. Each cycle it may take
// one col-wide vector of signed psums and adds it, lane by lane, into a running
// sum. Every add saturates. After acc_depth vectors the finished vector (with
// optional ReLU) is offered on a valid/ready output for write-back.
//
// Ports
//   clk        clock
//   reset      synchronous active-high reset
//   acc_valid  psum_in carries a vector this cycle
//   psum_in    signed psum vector, lane i at [psum_bw*(i+1)-1 : psum_bw*i]
//   relu_en    sampled with the last vector of a group; 1 clamps negative lanes to 0
//   clear      synchronous abort of the current group (drop_err is kept)
//   out_ready  consumer accepts sfp_out
//   out_valid  sfp_out holds a finished vector
//   sfp_out    finished vector
//   acc_cnt    number of vectors accepted into the current group
//   drop_err   sticky flag, set when a valid input had to be dropped

module sfp_accum #(
    parameter int psum_bw   = 16,
    parameter int col       = 8,
    parameter int acc_depth = 9
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             acc_valid,
    input  logic [psum_bw*col-1:0]           psum_in,
    input  logic                             relu_en,
    input  logic                             clear,
    input  logic                             out_ready,
    output logic                             out_valid,
    output logic [psum_bw*col-1:0]           sfp_out,
    output logic [$clog2(acc_depth+1)-1:0]   acc_cnt,
    output logic                             drop_err
);

    localparam int VW = psum_bw * col;
    localparam int CW = $clog2(acc_depth + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(acc_depth);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [VW-1:0]   accum;
    logic [VW-1:0]   accum_next;
    logic [VW-1:0]   sum;
    logic [CW-1:0]   cnt_next;
    logic            out_valid_next;
    logic [VW-1:0]   sfp_out_next;
    logic            drop_err_next;

    // Lane-wise signed add with one guard bit; a disagreement between the
    // guard bit and the lane sign bit means the result left the lane range.
    function automatic logic [VW-1:0] sat_add(input logic [VW-1:0] a,
                                              input logic [VW-1:0] b);
        logic [VW-1:0]    r;
        logic [psum_bw:0] s;
        r = '0;
        for (int i = 0; i < col; i++) begin
            s = {a[i*psum_bw+psum_bw-1], a[i*psum_bw +: psum_bw]}
              + {b[i*psum_bw+psum_bw-1], b[i*psum_bw +: psum_bw]};
            if (s[psum_bw] != s[psum_bw-1]) begin
                r[i*psum_bw +: psum_bw] = s[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}}
                                                     : {1'b0, {(psum_bw-1){1'b1}}};
            end else begin
                r[i*psum_bw +: psum_bw] = s[psum_bw-1:0];
            end
        end
        return r;
    endfunction

    // Zero every negative lane when ReLU is requested.
    function automatic logic [VW-1:0] relu(input logic [VW-1:0] x,
                                           input logic          en);
        logic [VW-1:0] r;
        r = x;
        for (int i = 0; i < col; i++) begin
            if (en && x[i*psum_bw+psum_bw-1]) begin
                r[i*psum_bw +: psum_bw] = '0;
            end
        end
        return r;
    endfunction

    assign sum = sat_add(accum, psum_in);

    // State and datapath registers. clear behaves like reset except that the
    // sticky drop flag survives it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            accum     <= '0;
            acc_cnt   <= '0;
            out_valid <= 1'b0;
            sfp_out   <= '0;
            drop_err  <= 1'b0;
        end else if (clear) begin
            state     <= IDLE;
            accum     <= '0;
            acc_cnt   <= '0;
            out_valid <= 1'b0;
            sfp_out   <= '0;
        end else begin
            state     <= state_next;
            accum     <= accum_next;
            acc_cnt   <= cnt_next;
            out_valid <= out_valid_next;
            sfp_out   <= sfp_out_next;
            drop_err  <= drop_err_next;
        end
    end

    // Next-state logic. In HOLD a new vector arriving together with the
    // handshake starts the next group immediately, so back-to-back groups
    // run without a bubble.
    always_comb begin
        state_next     = state;
        accum_next     = accum;
        cnt_next       = acc_cnt;
        out_valid_next = out_valid;
        sfp_out_next   = sfp_out;
        drop_err_next  = drop_err;

        unique case (state)
            IDLE: begin
                if (acc_valid) begin
                    accum_next = psum_in;
                    cnt_next   = ONE_C;
                    if (acc_depth == 1) begin
                        sfp_out_next   = relu(psum_in, relu_en);
                        out_valid_next = 1'b1;
                        state_next     = HOLD;
                    end else begin
                        state_next = ACCUM;
                    end
                end
            end

            ACCUM: begin
                if (acc_valid) begin
                    accum_next = sum;
                    cnt_next   = acc_cnt + ONE_C;
                    if (acc_cnt + ONE_C == DEPTH_C) begin
                        sfp_out_next   = relu(sum, relu_en);
                        out_valid_next = 1'b1;
                        state_next     = HOLD;
                    end
                end
            end

            HOLD: begin
                if (out_ready && acc_valid) begin
                    accum_next = psum_in;
                    cnt_next   = ONE_C;
                    if (acc_depth == 1) begin
                        sfp_out_next   = relu(psum_in, relu_en);
                        out_valid_next = 1'b1;
                    end else begin
                        out_valid_next = 1'b0;
                        state_next     = ACCUM;
                    end
                end else if (out_ready) begin
                    out_valid_next = 1'b0;
                    cnt_next       = '0;
                    state_next     = IDLE;
                end else if (acc_valid) begin
                    drop_err_next = 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sfp_accum.sv
// tb_sfp_accum
// Directed bench for sfp_accum. A small reference model accumulates every
// accepted vector with saturation; finished results are queued and compared
// when the bench completes the output handshake.

module tb_sfp_accum;

    localparam int BW    = 16;
    localparam int COL   = 8;
    localparam int DEPTH = 9;
    localparam int VW    = BW * COL;

    logic          clk = 1'b0;
    logic          reset;
    logic          acc_valid;
    logic [VW-1:0] psum_in;
    logic          relu_en;
    logic          clear;
    logic          out_ready;
    logic          out_valid;
    logic [VW-1:0] sfp_out;
    logic [3:0]    acc_cnt;
    logic          drop_err;

    int            vectors     = 0;
    int            miscompares = 0;
    int            dut_hs      = 0;

    logic [VW-1:0] expq[$];
    int            model[COL];
    int            mcnt  = 0;
    logic          mhold = 1'b0;
    logic          mdrop = 1'b0;

    sfp_accum #(.psum_bw(BW), .col(COL), .acc_depth(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .acc_valid (acc_valid),
        .psum_in   (psum_in),
        .relu_en   (relu_en),
        .clear     (clear),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .sfp_out   (sfp_out),
        .acc_cnt   (acc_cnt),
        .drop_err  (drop_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [VW-1:0] obs,
                               input logic [VW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] mk(input int lane, input logic [BW-1:0] v);
        logic [VW-1:0] r;
        r = '0;
        r[lane*BW +: BW] = v;
        return r;
    endfunction

    function automatic int clampInt(input int x);
        if (x > 32767)  return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    // One clock of stimulus. At the falling edge the pending result is
    // compared if this cycle completes the handshake, the model is advanced
    // and inputs are driven; just after the rising edge the control outputs
    // are compared with the model.
    task automatic applyStimulus(input logic v, input logic [VW-1:0] vec,
                                 input logic relu, input logic rdy, input logic clr);
        logic [VW-1:0] res;
        logic [BW-1:0] lane;
        @(negedge clk);
        if (out_valid && rdy) dut_hs++;
        if (!clr && mhold) begin
            if (expq.size() == 0) begin
                checkOutput("queue_empty", 1, 0);
            end else if (rdy) begin
                checkOutput("hs_sfp_out", sfp_out, expq.pop_front());
            end else begin
                checkOutput("hold_sfp_out", sfp_out, expq[0]);
            end
        end
        if (clr) begin
            mcnt  = 0;
            mhold = 1'b0;
            expq.delete();
        end else if (v && mhold && !rdy) begin
            mdrop = 1'b1;
        end else if (v) begin
            mhold = 1'b0;
            for (int i = 0; i < COL; i++) begin
                int x;
                x = int'($signed(vec[i*BW +: BW]));
                model[i] = (mcnt == 0) ? x : clampInt(model[i] + x);
            end
            mcnt++;
            if (mcnt == DEPTH) begin
                res = '0;
                for (int i = 0; i < COL; i++) begin
                    lane = model[i][BW-1:0];
                    res[i*BW +: BW] = (relu && model[i] < 0) ? '0 : lane;
                end
                expq.push_back(res);
                mhold = 1'b1;
                mcnt  = 0;
            end
        end else if (mhold && rdy) begin
            mhold = 1'b0;
        end
        acc_valid = v;
        psum_in   = vec;
        relu_en   = relu;
        out_ready = rdy;
        clear     = clr;
        @(posedge clk);
        #1;
        checkOutput("out_valid", out_valid, mhold);
        checkOutput("acc_cnt", acc_cnt, mhold ? DEPTH : mcnt);
        checkOutput("drop_err", drop_err, mdrop);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset     = 1'b1;
        acc_valid = 1'b0;
        clear     = 1'b0;
        mcnt      = 0;
        mhold     = 1'b0;
        mdrop     = 1'b0;
        expq.delete();
        @(posedge clk);
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_sfp_out", sfp_out, 0);
        checkOutput("rst_acc_cnt", acc_cnt, 0);
        checkOutput("rst_drop_err", drop_err, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic runGroup(input logic [VW-1:0] vec, input logic relu, input logic rdy);
        for (int k = 0; k < DEPTH; k++) applyStimulus(1'b1, vec, relu, rdy, 1'b0);
    endtask

    initial begin
        int hs0;
        reset     = 1'b1;
        acc_valid = 1'b0;
        psum_in   = '0;
        relu_en   = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        doReset();

        $display("[TB] step 1: lane0 1..9");
        for (int k = 1; k <= DEPTH; k++) applyStimulus(1'b1, mk(0, BW'(k)), 1'b0, 1'b1, 1'b0);
        checkOutput("t1_lane0", sfp_out[BW-1:0], 16'd45);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);

        $display("[TB] step 2: relu on negative lane");
        runGroup(mk(3, -16'sd5), 1'b1, 1'b1);
        checkOutput("t2_relu_lane3", sfp_out[3*BW +: BW], 16'h0000);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
        runGroup(mk(3, -16'sd5), 1'b0, 1'b1);
        checkOutput("t2_lane3", sfp_out[3*BW +: BW], 16'hFFD3);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);

        $display("[TB] step 3: saturation");
        runGroup(mk(1, 16'h7000) | mk(2, 16'h8000), 1'b0, 1'b1);
        checkOutput("t3_lane1", sfp_out[1*BW +: BW], 16'h7FFF);
        checkOutput("t3_lane2", sfp_out[2*BW +: BW], 16'h8000);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);

        $display("[TB] step 5: 27 back-to-back vectors");
        hs0 = dut_hs;
        for (int k = 0; k < 3 * DEPTH; k++) begin
            logic [VW-1:0] rv;
            for (int i = 0; i < COL; i++) rv[i*BW +: BW] = BW'($urandom);
            applyStimulus(1'b1, rv, k[0], 1'b1, 1'b0);
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
        checkOutput("t5_results", dut_hs - hs0, 3);

        $display("[TB] step 4: hold with dropped inputs");
        runGroup(mk(0, 16'd100), 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) applyStimulus(k[0], mk(0, 16'd7), 1'b0, 1'b0, 1'b0);
        checkOutput("t4_lane0", sfp_out[BW-1:0], 16'd900);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);

        $display("[TB] step 6: clear mid-group, reset mid-hold");
        for (int k = 0; k < 4; k++) applyStimulus(1'b1, mk(5, 16'd3), 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
        runGroup(mk(5, 16'd11), 1'b0, 1'b1);
        checkOutput("t6_lane5", sfp_out[5*BW +: BW], 16'd99);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
        runGroup(mk(4, 16'd2), 1'b0, 1'b0);
        doReset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
